// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target register block.
//   i2c_tgt_state_t      - target FSM states
//   I2C_IOEXP_ADDR_BASE  - default 7-bit target address
//   CMD_*                - register indices of the IO-expander style register map
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic [6:0] I2C_IOEXP_ADDR_BASE = 7'h20;

  localparam int CMD_IN0  = 0;
  localparam int CMD_OUT0 = 2;
  localparam int CMD_OUT1 = 3;
  localparam int CMD_CFG0 = 6;
  localparam int CMD_CFG1 = 7;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one I2C pin for the target FSM.
//   pin   - raw pin input (asynchronous to clk)
//   level - filtered line value (resets high, the idle bus level)
//   rise  - one-clk pulse in the first cycle level reads 1 after being 0
//   fall  - one-clk pulse in the first cycle level reads 0 after being 1
// A 2-FF synchronizer feeds a filter that adopts a new value only after
// FILT_LEN consecutive synchronized samples disagree with the current one.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], pin};
    filt_d = filt_q;
    cnt_d  = '0;
    // Any sample matching the current level restarts the run count.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                            cnt_d  = cnt_q + 1'b1;
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = filt_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing NUM_REGS 8-bit registers with a
// pointer byte, auto-increment, repeated START and multi-byte reads.
//   clk, reset - system clock, synchronous active-high reset
//   scl        - SCL pin (input only, no clock stretching)
//   sda_in     - SDA pin sample
//   sda_oe_n   - 0 pulls SDA low, 1 releases it (open drain)
//   regs_out   - register image, reg i at [8*i+7:8*i]
//   wr_strobe  - one-clk pulse per register write, wr_index = register written
//   busy       - high from an address-matched START until STOP or read NACK
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = I2C_IOEXP_ADDR_BASE,
  parameter int         NUM_REGS = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl,
  input  logic                        sda_in,
  output logic                        sda_oe_n,
  output logic [8*NUM_REGS-1:0]       regs_out,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        busy
);
  localparam int PW = $clog2(NUM_REGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .pin(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .pin(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  i2c_tgt_state_t               state_q, state_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic [7:0]                   sh_q, sh_d;
  logic [PW-1:0]                ptr_q, ptr_d, ptr_inc;
  logic [NUM_REGS-1:0][7:0]     regs_q, regs_d;
  logic                         oe_n_q, oe_n_d;
  logic                         busy_q, busy_d;
  logic                         ack_ph_q, ack_ph_d;
  logic                         rw_q, rw_d;
  logic                         wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]                wr_index_q, wr_index_d;
  logic [7:0]                   byte_in;

  assign byte_in = {sh_q[6:0], sda_lvl};
  assign ptr_inc = ptr_q + 1'b1;

  // The module parameter ADDR shadows the imported state name, so the
  // address-shift state is always written with its package scope.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    oe_n_d      = oe_n_q;
    busy_d      = busy_q;
    ack_ph_d    = ack_ph_q;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;

    if (start) begin
      // Repeated START keeps ptr so a pointer write can precede a read.
      state_d   = i2c_pkg::ADDR;
      bit_cnt_d = '0;
      oe_n_d    = 1'b1;
      ack_ph_d  = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      oe_n_d    = 1'b1;
      busy_d    = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        i2c_pkg::ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                i2c_pkg::ADDR: begin
                  if (byte_in[7:1] == ADDR) begin
                    state_d = ADDR_ACK;
                    busy_d  = 1'b1;
                    rw_d    = byte_in[0];
                  end else begin
                    state_d = IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                PTR: begin
                  ptr_d   = byte_in[PW-1:0];
                  state_d = PTR_ACK;
                end
                default: begin
                  regs_d[ptr_q] = byte_in;
                  wr_strobe_d   = 1'b1;
                  wr_index_d    = ptr_q;
                  state_d       = WDATA_ACK;
                end
              endcase
            end
          end
        end

        // ack_ph splits the 9th clock: first fall pulls SDA low, the
        // following fall ends the ACK and moves on.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              oe_n_d   = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              oe_n_d    = 1'b1;
              bit_cnt_d = '0;
              case (state_q)
                ADDR_ACK: begin
                  if (rw_q) begin
                    state_d = RDATA;
                    sh_d    = regs_q[ptr_q];
                    oe_n_d  = regs_q[ptr_q][7];
                  end else begin
                    state_d = PTR;
                  end
                end
                PTR_ACK: state_d = WDATA;
                default: begin
                  state_d = WDATA;
                  ptr_d   = ptr_inc;
                end
              endcase
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
          end else if (scl_fall) begin
            sh_d   = {sh_q[6:0], 1'b0};
            oe_n_d = sh_q[6];
          end
        end

        // Release for the controller's ACK, sample it on the 9th rise, and
        // on ACK drive the next byte's MSB at the following fall.
        RDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              oe_n_d   = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              state_d   = RDATA;
              oe_n_d    = sh_q[7];
              ack_ph_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end else if (scl_rise && ack_ph_q) begin
            if (sda_lvl) begin
              state_d  = IGNORE;
              busy_d   = 1'b0;
              ack_ph_d = 1'b0;
            end else begin
              ptr_d = ptr_inc;
              sh_d  = regs_q[ptr_inc];
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      regs_q      <= '0;
      oe_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      oe_n_q      <= oe_n_d;
      busy_q      <= busy_d;
      ack_ph_q    <= ack_ph_d;
      rw_q        <= rw_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
    end
  end

  assign sda_oe_n  = oe_n_q;
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = busy_q;

endmodule
